// File: rtl/mem_access_stage_if.sv
// Data bus between the memory stage and the data memory: one outstanding
// request, held until ack; rdata is valid in the ack cycle.
interface mem_access_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS memory stage: load/store bus controller with pipeline stall plus the MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with an align_err pulse.
module mem_access_stage #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                MEM_RegWrite,
  input  logic                MEM_MemToReg,
  input  logic                MEM_MEM_WREN,
  input  logic                MEM_MEM_RDEN,
  input  logic [31:0]         MEM_ALUResult,
  input  logic [31:0]         MEM_StoreData,
  input  logic [1:0]          MEM_Size,
  input  logic                MEM_Unsigned,
  input  logic [4:0]          MEM_RD,
  mem_access_stage_if.master  bus,
  output logic                stall,
  output logic                bus_err,
  output logic                align_err,
  output logic                WB_RegWrite,
  output logic                WB_MemToReg,
  output logic [31:0]         WB_ReadData,
  output logic [31:0]         WB_ALUResult,
  output logic [4:0]          WB_RD
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [15:0] LAST_WAIT = 16'(BUS_TIMEOUT - 1);

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic        regwrite_reg;
  logic        memtoreg_reg;
  logic [4:0]  rd_reg;
  logic [31:0] alu_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;

  logic        access;
  logic        misaligned;
  logic        in_idle;
  logic        in_wait;
  logic        timeout;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign access  = MEM_MEM_WREN | MEM_MEM_RDEN;
  assign in_idle = (state_reg == ST_IDLE);
  assign in_wait = (state_reg == ST_WAIT);
  assign timeout = (cnt_reg == LAST_WAIT);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((MEM_Size == 2'b01) & MEM_ALUResult[0])
                    | (MEM_Size[1] & (MEM_ALUResult[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Gated by reset so the upstream pipeline is released the instant reset asserts.
  assign stall     = ~reset & ((in_idle & access & ~misaligned)
                             | (in_wait & ~bus.bus_ack & ~timeout));
  assign align_err = ~reset & in_idle & access & misaligned;
  assign bus_err   = in_wait & ~bus.bus_ack & timeout;

  always_comb begin
    req_be    = 4'b1111;
    req_wdata = MEM_StoreData;
    case (MEM_Size)
      2'b00: begin
        req_be    = 4'b0001 << MEM_ALUResult[1:0];
        req_wdata = {4{MEM_StoreData[7:0]}};
      end
      2'b01: begin
        req_be    = MEM_ALUResult[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{MEM_StoreData[15:0]}};
      end
      default: ;
    endcase
  end

  assign load_byte = bus.bus_rdata[{alu_reg[1:0], 3'b000} +: 8];
  assign load_half = alu_reg[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

  always_comb begin
    load_data = bus.bus_rdata;
    case (size_reg)
      2'b00:   load_data = unsigned_reg ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_data = unsigned_reg ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      regwrite_reg  <= 1'b0;
      memtoreg_reg  <= 1'b0;
      rd_reg        <= '0;
      alu_reg       <= '0;
      size_reg      <= '0;
      unsigned_reg  <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      WB_RegWrite   <= 1'b0;
      WB_MemToReg   <= 1'b0;
      WB_RD         <= '0;
      WB_ReadData   <= '0;
      WB_ALUResult  <= '0;
    end else begin
      // Bubble unless a branch below delivers a real result.
      WB_RegWrite  <= 1'b0;
      WB_MemToReg  <= 1'b0;
      WB_RD        <= '0;
      WB_ReadData  <= '0;
      WB_ALUResult <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (!access) begin
            WB_RegWrite  <= MEM_RegWrite;
            WB_MemToReg  <= MEM_MemToReg;
            WB_RD        <= MEM_RD;
            WB_ALUResult <= MEM_ALUResult;
          end else if (!misaligned) begin
            regwrite_reg  <= MEM_RegWrite;
            memtoreg_reg  <= MEM_MemToReg;
            rd_reg        <= MEM_RD;
            alu_reg       <= MEM_ALUResult;
            size_reg      <= MEM_Size;
            unsigned_reg  <= MEM_Unsigned;
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= MEM_MEM_WREN;
            bus.bus_addr  <= {MEM_ALUResult[31:2], 2'b00};
            bus.bus_be    <= req_be;
            bus.bus_wdata <= req_wdata;
            cnt_reg       <= '0;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.bus_ack || timeout) begin
            bus.bus_req  <= 1'b0;
            state_reg    <= ST_IDLE;
            WB_RegWrite  <= bus.bus_ack & regwrite_reg;
            WB_MemToReg  <= memtoreg_reg;
            WB_RD        <= rd_reg;
            WB_ALUResult <= alu_reg;
            if (bus.bus_ack && !bus.bus_we)
              WB_ReadData <= load_data;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level model of the
// memory stage; a simple memory responder acks after a per-op latency (0 = never).
module tb_mem_access_stage;
  localparam int unsigned TIMEOUT = 4;

  typedef struct {
    logic        rw;
    logic        mtr;
    logic        wren;
    logic        rden;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          lat;
  } op_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        MEM_RegWrite, MEM_MemToReg, MEM_MEM_WREN, MEM_MEM_RDEN;
  logic [31:0] MEM_ALUResult, MEM_StoreData;
  logic [1:0]  MEM_Size;
  logic        MEM_Unsigned;
  logic [4:0]  MEM_RD;
  logic        stall, bus_err, align_err;
  logic        WB_RegWrite, WB_MemToReg;
  logic [31:0] WB_ReadData, WB_ALUResult;
  logic [4:0]  WB_RD;

  int n_checks = 0;
  int n_fail   = 0;
  int op_num   = 0;

  mem_access_stage_if bus();

  mem_access_stage #(.BUS_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg),
    .MEM_MEM_WREN(MEM_MEM_WREN), .MEM_MEM_RDEN(MEM_MEM_RDEN),
    .MEM_ALUResult(MEM_ALUResult), .MEM_StoreData(MEM_StoreData),
    .MEM_Size(MEM_Size), .MEM_Unsigned(MEM_Unsigned), .MEM_RD(MEM_RD),
    .bus(bus.master),
    .stall(stall), .bus_err(bus_err), .align_err(align_err),
    .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
    .WB_ReadData(WB_ReadData), .WB_ALUResult(WB_ALUResult), .WB_RD(WB_RD)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 4'(1 << (addr % 4));
    if (size == 2'd1) return ((addr & 32'd2) != 0) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] sd);
    if (size == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] rdata);
    int    width;
    int    off;
    longint v;
    width = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    off   = (size == 2'd0) ? int'(addr % 4) : (size == 2'd1) ? int'(addr & 32'd2) : 0;
    v = longint'((64'(rdata) >> (8 * off)) & ((64'd1 << width) - 64'd1));
    if (!uns && width < 32 && v >= (longint'(1) << (width - 1)))
      v = v - (longint'(1) << width);
    return 32'(v);
  endfunction

  function automatic bit exp_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
    return (size == 2'd1 && (addr % 2) != 0) || (size >= 2'd2 && (addr % 4) != 0);
`else
    return (size == 2'd3) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  task automatic drive_nop();
    MEM_MEM_WREN = 1'b0;
    MEM_MEM_RDEN = 1'b0;
    MEM_RegWrite = 1'b0;
    MEM_MemToReg = 1'b0;
    MEM_RD       = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that ends the op.
  task automatic run_op(input op_t op);
    bit access, mis, mem, store, tmo, done, seen;
    int k, stalls, reqs, errs, aligns;
    logic [31:0] e_rw, e_mtr, e_rd, e_alu, e_data;
    access = op.wren | op.rden;
    mis    = access && exp_misaligned(op.size, op.alu);
    mem    = access && !mis;
    store  = op.wren;
    if (op.lat <= 0 || op.lat > int'(TIMEOUT)) begin k = int'(TIMEOUT); tmo = 1; end
    else begin k = op.lat; tmo = 0; end
    if (!mem) begin k = 0; tmo = 0; end
    stalls = 0; reqs = 0; errs = 0; aligns = 0; done = 0; seen = 0;

    MEM_RegWrite  = op.rw;   MEM_MemToReg = op.mtr;
    MEM_MEM_WREN  = op.wren; MEM_MEM_RDEN = op.rden;
    MEM_ALUResult = op.alu;  MEM_StoreData = op.sd;
    MEM_Size      = op.size; MEM_Unsigned = op.uns;
    MEM_RD        = op.rd;

    for (int c = 0; c < 64 && !done; c++) begin
      if (bus.bus_req) reqs++;
      bus.bus_ack   = bus.bus_req && (reqs == op.lat);
      bus.bus_rdata = bus.bus_req ? op.rdata : $urandom;
      @(negedge clock);
      if (bus.bus_req && !seen) begin
        seen = 1;
        check_eq("bus_addr", bus.bus_addr, op.alu & 32'hFFFF_FFFC);
        check_eq("bus_be", 32'(bus.bus_be), 32'(exp_be(op.size, op.alu)));
        check_eq("bus_we", 32'(bus.bus_we), 32'(store));
        if (store) check_eq("bus_wdata", bus.bus_wdata, exp_wdata(op.size, op.sd));
      end
      stalls += int'(stall);
      errs   += int'(bus_err);
      aligns += int'(align_err);
      if (!stall) begin
        done = 1;
        check_eq("bus_err_at_done", 32'(bus_err), 32'(tmo));
        check_eq("align_err_at_done", 32'(align_err), 32'(mis));
      end
      @(posedge clock); #1;
    end
    bus.bus_ack = 1'b0;
    check_eq("op_completed", 32'(done), 32'd1);
    check_eq("stall_cycles", 32'(stalls), 32'(k));
    check_eq("req_cycles", 32'(reqs), 32'(k));
    check_eq("bus_err_pulses", 32'(errs), 32'(tmo));
    check_eq("align_err_pulses", 32'(aligns), 32'(mis));

    if (!access) begin
      e_rw = 32'(op.rw); e_mtr = 32'(op.mtr); e_rd = 32'(op.rd); e_alu = op.alu; e_data = 0;
    end else if (mis) begin
      e_rw = 0; e_mtr = 0; e_rd = 0; e_alu = 0; e_data = 0;
    end else begin
      e_rw   = tmo ? 32'd0 : 32'(op.rw);
      e_mtr  = 32'(op.mtr);
      e_rd   = 32'(op.rd);
      e_alu  = op.alu;
      e_data = (tmo || store) ? 32'd0 : exp_load(op.size, op.uns, op.alu, op.rdata);
    end
    check_eq("WB_RegWrite", 32'(WB_RegWrite), e_rw);
    check_eq("WB_MemToReg", 32'(WB_MemToReg), e_mtr);
    check_eq("WB_RD", 32'(WB_RD), e_rd);
    check_eq("WB_ALUResult", WB_ALUResult, e_alu);
    check_eq("WB_ReadData", WB_ReadData, e_data);
    drive_nop();
    $display("op %0d: wren=%0b rden=%0b size=%0d addr=0x%08h lat=%0d stalls=%0d wb_data=0x%08h",
             op_num, op.wren, op.rden, op.size, op.alu, op.lat, stalls, WB_ReadData);
    op_num++;
  endtask

  task automatic reset_mid_wait();
    MEM_MEM_RDEN = 1'b1; MEM_MEM_WREN = 1'b0; MEM_RegWrite = 1'b1; MEM_MemToReg = 1'b1;
    MEM_Size = 2'd2; MEM_ALUResult = 32'h500; MEM_RD = 5'd9;
    bus.bus_ack = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_eq("rst_pre_req", 32'(bus.bus_req), 32'd1);
    check_eq("rst_pre_stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_req", 32'(bus.bus_req), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_wb_rw", 32'(WB_RegWrite), 32'd0);
    check_eq("rst_wb_rd", 32'(WB_RD), 32'd0);
    check_eq("rst_wb_data", WB_ReadData, 32'd0);
    check_eq("rst_wb_alu", WB_ALUResult, 32'd0);
    drive_nop();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    $display("op %0d: reset asserted during WAIT", op_num);
    op_num++;
  endtask

  function automatic op_t mk(input logic wren, input logic rden, input logic [1:0] size,
                             input logic uns, input logic [31:0] alu, input logic [31:0] sd,
                             input logic [31:0] rdata, input int lat, input logic [4:0] rd,
                             input logic rw);
    op_t o;
    o.wren = wren; o.rden = rden; o.size = size; o.uns = uns; o.alu = alu; o.sd = sd;
    o.rdata = rdata; o.lat = lat; o.rd = rd; o.rw = rw; o.mtr = rden & ~wren;
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    reset = 1'b1;
    drive_nop();
    MEM_ALUResult = '0; MEM_StoreData = '0; MEM_Size = '0; MEM_Unsigned = 1'b0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_req", 32'(bus.bus_req), 32'd0);
    check_eq("reset_stall", 32'(stall), 32'd0);
    check_eq("reset_bus_err", 32'(bus_err), 32'd0);
    check_eq("reset_align_err", 32'(align_err), 32'd0);
    check_eq("reset_addr", bus.bus_addr, 32'd0);
    check_eq("reset_be", 32'(bus.bus_be), 32'd0);
    check_eq("reset_wdata", bus.bus_wdata, 32'd0);
    check_eq("reset_we", 32'(bus.bus_we), 32'd0);
    check_eq("reset_wb_rw", 32'(WB_RegWrite), 32'd0);
    check_eq("reset_wb_data", WB_ReadData, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    run_op(mk(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0, 32'h0, 1, 5'd5, 1'b1));
    run_op(mk(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80AABBCC, 3, 5'd7, 1'b1));
    run_op(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'hDEADBEEF, 32'h0, 1, 5'd0, 1'b0));
    run_op(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'h0, 32'h12345678, 0, 5'd3, 1'b1));
    run_op(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h302, 32'h0, 32'hCAFEF00D, 2, 5'd4, 1'b1));
    run_op(mk(1'b0, 1'b1, 2'd1, 1'b1, 32'h606, 32'h0, 32'h9876_5432, 1, 5'd8, 1'b1));
    run_op(mk(1'b1, 1'b1, 2'd0, 1'b0, 32'h701, 32'h55, 32'h0, 2, 5'd1, 1'b0));
    reset_mid_wait();
    run_op(mk(1'b0, 1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80AABBCC, 1, 5'd6, 1'b1));

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind   = int'($urandom_range(0, 3));
      o.wren = (kind >= 2);
      o.rden = (kind == 1) || (kind == 3);
      o.size = 2'($urandom_range(0, 3));
      o.uns  = 1'($urandom_range(0, 1));
      o.alu  = $urandom;
      o.sd   = $urandom;
      o.rdata = $urandom;
      o.lat  = int'($urandom_range(0, 6));
      o.rd   = 5'($urandom_range(0, 31));
      o.rw   = 1'($urandom_range(0, 1));
      o.mtr  = 1'($urandom_range(0, 1));
      run_op(o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage access controller and MEM/WB pipeline register for the five-stage MIPS CPU. It consumes the EX/MEM register outputs, runs loads and stores over a single-outstanding request/acknowledge data bus with byte lanes, stalls the upstream pipeline while an access is pending, and registers the write-back values. Non-memory instructions pass through in one cycle.

## Interface
- BUS_TIMEOUT, 255: WAIT cycles without ack before the access is abandoned (1..65535)
- clock  input  1  pipeline clock
- reset  input  1  asynchronous, active-high
- MEM_RegWrite, MEM_MemToReg, MEM_MEM_WREN, MEM_MEM_RDEN  input  1 each  control signals from the EX/MEM register
- MEM_ALUResult  input  32  effective address or ALU result
- MEM_StoreData  input  32  store source data, right-justified
- MEM_Size  input  2  00 byte, 01 half, 10/11 word
- MEM_Unsigned  input  1  zero-extend loads when 1, sign-extend when 0
- MEM_RD  input  5  destination register
- bus_req  output  1  access request, held until ack
- bus_we  output  1  1 store, 0 load
- bus_addr  output  32  word address {MEM_ALUResult[31:2],2'b00}
- bus_be  output  4  byte enables, little-endian (bit0 = addr[1:0]==0)
- bus_wdata  output  32  lane-replicated store data
- bus_ack  input  1  access complete; rdata valid this cycle
- bus_rdata  input  32  load data
- stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM
- bus_err  output  1  one-cycle timeout pulse
- align_err  output  1  one-cycle misaligned pulse (0 when the alignment check is compiled out)
- WB_RegWrite, WB_MemToReg  output  1 each  registered controls
- WB_ReadData, WB_ALUResult  output  32 each  registered load data / ALU result
- WB_RD  output  5  registered destination register

## Operation
- Access condition: WREN or RDEN. If both are set, the access is a store.
- FSM states:
  - IDLE: on an access, latch addr/be/wdata/we, assert stall combinationally, and go to WAIT. Otherwise the WB registers take the MEM inputs directly (WB_ReadData=0).
  - WAIT: bus_req=1 with latched fields stable. On bus_ack, capture data, drop stall that cycle, and return to IDLE. Without bus_ack, hold stall and increment the timeout counter.
  - Timeout: when the counter reaches BUS_TIMEOUT, pulse bus_err, complete with WB_ReadData=0 and WB_RegWrite=0, and return to IDLE.
- stall = (IDLE & access & ~misaligned) | (WAIT & ~bus_ack & ~timeout).
- While stalled, the WB registers load a bubble: RegWrite=0, MemToReg=0, RD=0, data=0.
- On completion, the WB registers take the latched RD/RegWrite/MemToReg. For a store, WB_RegWrite takes MEM_RegWrite as decoded, normally 0.
- Byte access: be=1<<addr[1:0]; wdata={4{StoreData[7:0]}}.
- Half access: be = addr[1] ? 1100 : 0011; wdata={2{StoreData[15:0]}}.
- Word access: be=1111; wdata=StoreData.
- Load extraction: select the lane by addr bits, then extend to 32 bits per MEM_Unsigned.
- bus_ack in IDLE is ignored.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 (bus_req, stall, errs, all WB_*, bus_addr/be/wdata/we).
- Reset mid-WAIT drops bus_req immediately (async); the access is lost.
- Non-memory op: WB registers update at the edge ending its MEM cycle. Latency 1, no stall.
- Memory op presented in cycle 0: bus_req rises in cycle 1. The earliest ack is in cycle 1, which gives the result in the WB registers after the edge ending cycle 1. Minimum 1 stall cycle; N-cycle ack latency gives N stall cycles.
- bus_err and align_err assert for exactly the one cycle in which the access completes.
- Back-to-back memory ops: IDLE is re-entered for one cycle between them, and that cycle asserts stall again for the next op.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - Detects half with addr[0]=1, or word with addr[1:0]≠0.
  - On detection: no bus access and no stall; pulse align_err; write a bubble (WB_RegWrite=0).
- MEM_ALIGN_CHECK_EN undefined:
  - The low address bits are ignored for those sizes: half uses addr[1] only, word uses none.
  - align_err is tied 0.

## Test plan
- ALU op, ALUResult=0x1234, RD=5, RegWrite=1 -> WB_ALUResult=0x1234, WB_RD=5 next edge; stall never asserts.
- lb signed, addr 0x103, rdata 0x80AABBCC, ack after 3 WAIT cycles -> 3 stall cycles, be=1000, WB_ReadData=0xFFFFFF80.
- sh addr 0x202, StoreData 0xDEADBEEF -> bus_addr=0x200, be=1100, wdata=0xBEEFBEEF, we=1, one-cycle ack, single stall cycle.
- Load with BUS_TIMEOUT=4, ack never asserts -> bus_req for 4 cycles, bus_err pulse, WB_RegWrite=0, stall released.
- lw addr 0x302 -> with MEM_ALIGN_CHECK_EN: align_err=1, no bus_req, no stall; without it: bus_addr=0x300, be=1111.
- Async reset asserted during WAIT -> bus_req and stall 0 immediately, all WB_* zero, next access starts from IDLE.
